// File: rtl/alu_uart_if.sv
// Sequencer between a UART receiver, a combinational ALU and a UART transmitter:
// collects A, B, OP bytes, registers the ALU result and hands it to the transmitter.
// Optional macro ALU_IF_TIMEOUT_EN adds an idle-byte timeout and the o_timeout port.
module alu_uart_if #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
`ifdef ALU_IF_TIMEOUT_EN
  output logic               o_timeout,
`endif
  output logic               o_busy
);

  typedef enum logic [2:0] {
    WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX
  } state_e;

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;

`ifdef ALU_IF_TIMEOUT_EN
  localparam int NB_CNT = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT_CYCLES - 1);

  logic [NB_CNT-1:0] cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic              in_operand_wait;
`else
  // Parameter sanity check; the timeout itself does not exist in this build.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;

    case (state_q)
      WAIT_A: if (i_rx_done) begin
        data_a_d = i_rx_data;
        state_d  = WAIT_B;
      end
      WAIT_B: if (i_rx_done) begin
        data_b_d = i_rx_data;
        state_d  = WAIT_OP;
      end
      WAIT_OP: if (i_rx_done) begin
        op_d    = i_rx_data[NB_OP-1:0];
        state_d = EXEC;
      end
      // Operands have been stable for one cycle, so the ALU output is settled.
      EXEC: begin
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        state_d    = SEND;
      end
      SEND:    state_d = WAIT_TX;
      // A byte arriving with i_tx_done is dropped rather than captured as A.
      WAIT_TX: if (i_tx_done) state_d = WAIT_A;
      default: state_d = WAIT_A;
    endcase

`ifdef ALU_IF_TIMEOUT_EN
    timeout_d       = 1'b0;
    in_operand_wait = (state_q == WAIT_B) || (state_q == WAIT_OP);
    if (in_operand_wait && !i_rx_done && (cnt_q == CNT_LAST)) begin
      state_d   = WAIT_A;
      timeout_d = 1'b1;
    end
    if (!in_operand_wait || i_rx_done || (state_d != state_q)) cnt_d = '0;
    else                                                       cnt_d = cnt_q + 1'b1;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= WAIT_A;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
`ifdef ALU_IF_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
`ifdef ALU_IF_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_op       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = (state_q == EXEC) || (state_q == SEND) || (state_q == WAIT_TX);
`ifdef ALU_IF_TIMEOUT_EN
  assign o_timeout  = timeout_q;
`endif

endmodule

// File: doc/alu_uart_if.md
Name: alu_uart_if

Overview:
- Sequencing stage that feeds operands and opcode into the combinational ALU and returns its result.
- Upstream: a UART receiver delivering one byte per `i_rx_done` pulse. Downstream: the ALU, then a UART transmitter.
- Collects A, B, OP as three serial bytes, lets the ALU settle one cycle, registers the result, and handshakes it to the transmitter.

Parameters:
- NB_DATA, 8, width of operands, result and UART byte.
- NB_OP, 6, opcode width driven to the ALU.
- TIMEOUT_CYCLES, 1000000, idle-byte timeout in clocks; used only when ALU_IF_TIMEOUT_EN is defined.

Ports:
- i_clk  in  1  system clock, all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rx_data  in  NB_DATA  received byte, valid while i_rx_done=1.
- i_rx_done  in  1  one-cycle pulse, new byte on i_rx_data.
- i_tx_done  in  1  one-cycle pulse, transmitter finished the byte.
- i_alu_result  in  NB_DATA  ALU output (signed).
- o_data_a  out  NB_DATA  registered operand A to ALU.
- o_data_b  out  NB_DATA  registered operand B to ALU.
- o_op  out  NB_OP  registered opcode to ALU.
- o_tx_data  out  NB_DATA  registered result byte to transmitter.
- o_tx_start  out  1  one-cycle registered request to transmit o_tx_data.
- o_busy  out  1  high while a result is pending or being sent.

Behaviour:
- Reset (async assert, sync release):
  - State = WAIT_A.
  - o_data_a, o_data_b, o_op, o_tx_data all zero.
  - o_tx_start = 0, o_busy = 0.
  - Reset mid-operation discards all partial input and any pending transmit.
- FSM states: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- WAIT_A: on i_rx_done, o_data_a <= i_rx_data; go to WAIT_B.
- WAIT_B: on i_rx_done, o_data_b <= i_rx_data; go to WAIT_OP.
- WAIT_OP: on i_rx_done, o_op <= i_rx_data[NB_OP-1:0]; go to EXEC.
  - Upper byte bits are dropped.
  - Undefined opcodes pass through unchanged; the ALU returns 0 for them.
- EXEC: lasts exactly one cycle, which is the ALU settle time.
  - o_tx_data <= i_alu_result.
  - o_tx_start <= 1.
  - Go to SEND.
- SEND: lasts exactly one cycle.
  - o_tx_start is 1 during this cycle and drops to 0 on exit.
  - Go to WAIT_TX.
- WAIT_TX: hold until i_tx_done, then go to WAIT_A.
- Latency: if the op byte is sampled at edge N, o_tx_start is high from edge N+1 to edge N+2. o_tx_data is stable from edge N+1 until the next EXEC.
- o_busy = 1 in EXEC, SEND and WAIT_TX; 0 otherwise.
- i_rx_done while in EXEC, SEND or WAIT_TX: byte is dropped, no state change.
- i_rx_done and i_tx_done in the same WAIT_TX cycle: return to WAIT_A, and the byte is dropped (not captured as A).
- i_tx_done outside WAIT_TX: ignored.
- o_data_a, o_data_b and o_op hold their values until overwritten by the next capture. They are never cleared except by reset.
- No arithmetic in this block. Bytes are stored bit-exact; sign interpretation belongs to the ALU.

Optional Feature:
- Macro: ALU_IF_TIMEOUT_EN.
- Defined:
  - A counter clears on every i_rx_done and on every state change.
  - It increments each cycle while in WAIT_B or WAIT_OP.
  - When it reaches TIMEOUT_CYCLES-1, the FSM returns to WAIT_A, and output o_timeout (1 bit, reset 0) pulses high for one cycle.
  - Already-latched operand registers keep their values.
- Not defined:
  - No counter and no o_timeout port.
  - The FSM waits indefinitely in WAIT_B/WAIT_OP.

Test Plan:
- ADD: rx bytes 0x05, 0x03, 0x20 → o_data_a=0x05, o_data_b=0x03, o_op=0x20. One o_tx_start pulse, 1 cycle after the op byte, with o_tx_data=0x08. o_busy high until i_tx_done.
- SUB negative: rx 0x03, 0x05, 0x22 → o_tx_data=0xFE. SRA: rx 0x80, 0x02, 0x03 → o_tx_data=0xE0. Op byte 0xE0 → o_op=0x20.
- Busy drop: after the op byte, send rx 0x77 during WAIT_TX, then i_tx_done → state WAIT_A and o_data_a unchanged. A following sequence 0x01, 0x01, 0x24 → o_tx_data=0x01.
- Reset mid-op: rx 0x10, 0x20, then i_rst_n low 3 cycles → all outputs 0 and state WAIT_A. The next three bytes are treated as A, B, OP.
- Simultaneous: i_rx_done(0x55) and i_tx_done in the same WAIT_TX cycle → state WAIT_A, o_data_a not 0x55, no extra o_tx_start.
- With ALU_IF_TIMEOUT_EN and TIMEOUT_CYCLES=16: rx 0x09, then idle 16 cycles → o_timeout pulses once and state is WAIT_A. Next bytes 0x02, 0x03, 0x25 → o_tx_data=0x03.
